// File: rtl/fifo_matrix_tx_arbiter_if.sv
// Requester-side handshake/data and FIFO write-side signals of one tx arbiter.
interface fifo_matrix_tx_arbiter_if #(
  parameter int unsigned PORT_COUNT = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [PORT_COUNT-1:0]            req_valid;
  logic [PORT_COUNT-1:0]            req_ready;
  logic [PORT_COUNT*DATA_WIDTH-1:0] in_data;
  logic [PORT_COUNT-1:0]            in_last;
  logic                             fifo_prog_full;
  logic                             fifo_wr_en;
  logic [DATA_WIDTH-1:0]            fifo_din;
  logic                             fifo_last;

  // Arbiter side
  modport slave (
    input  req_valid, in_data, in_last, fifo_prog_full,
    output req_ready, fifo_wr_en, fifo_din, fifo_last
  );

  // Requesters plus FIFO side
  modport master (
    output req_valid, in_data, in_last, fifo_prog_full,
    input  req_ready, fifo_wr_en, fifo_din, fifo_last
  );
endinterface

// File: rtl/fifo_matrix_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of one output port's tx data FIFO.
// Grants only when prog_full is low, streams the granted frame one byte per
// cycle, truncates frames longer than MAX_FRAME_BYTES and counts good frames.
module fifo_matrix_tx_arbiter #(
  parameter int unsigned PORT_COUNT      = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic                          clk,
  input  logic                          reset_n,
  fifo_matrix_tx_arbiter_if.slave       bus,
  output logic                          busy,
  output logic [$clog2(PORT_COUNT)-1:0] grant_idx,
  output logic                          err_oversize,
  output logic [31:0]                   frame_count
);

  localparam int unsigned IDX_W = $clog2(PORT_COUNT);
  localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PORT_COUNT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        byte_cnt;
  logic [PORT_COUNT-1:0]   req_ready_q;
  logic                    fifo_wr_en_q;
  logic [DATA_WIDTH-1:0]   fifo_din_q;
  logic                    fifo_last_q;

  logic                    gnt_found_c;
  logic [IDX_W-1:0]        gnt_sel_c;
  logic [DATA_WIDTH-1:0]   cur_byte_c;
  logic                    cur_last_c;
  int unsigned             cand;

  assign bus.req_ready  = req_ready_q;
  assign bus.fifo_wr_en = fifo_wr_en_q;
  assign bus.fifo_din   = fifo_din_q;
  assign bus.fifo_last  = fifo_last_q;

  // First pending requester at or after rr_ptr, wrapping around
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_sel_c   = '0;
    cand        = 0;
    for (int unsigned off = 0; off < PORT_COUNT; off++) begin
      cand = (32'(rr_ptr) + off) % PORT_COUNT;
      if (!gnt_found_c && bus.req_valid[cand]) begin
        gnt_found_c = 1'b1;
        gnt_sel_c   = IDX_W'(cand);
      end
    end
  end

  // Byte and last flag of the granted requester
  always_comb begin
    cur_byte_c = '0;
    cur_last_c = 1'b0;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      if (grant_idx == IDX_W'(p)) begin
        cur_byte_c = bus.in_data[p*DATA_WIDTH +: DATA_WIDTH];
        cur_last_c = bus.in_last[p];
      end
    end
  end

  // Arbitration FSM with registered grant, FIFO write and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      byte_cnt     <= '0;
      frame_count  <= '0;
      req_ready_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      fifo_last_q  <= 1'b0;
      err_oversize <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_last_q  <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (|req_ready_q) begin
            // Grant pulse is on the wire; byte 0 arrives next cycle
            state <= XFER;
            busy  <= 1'b1;
          end else if (!bus.fifo_prog_full && gnt_found_c) begin
            req_ready_q <= PORT_COUNT'(1) << gnt_sel_c;
            grant_idx   <= gnt_sel_c;
            rr_ptr      <= (gnt_sel_c == IDX_LAST) ? '0 : gnt_sel_c + IDX_W'(1);
            byte_cnt    <= '0;
          end
        end
        XFER: begin
          fifo_wr_en_q <= 1'b1;
          fifo_din_q   <= cur_byte_c;
          if (byte_cnt != CNT_SAT) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
          if (cur_last_c) begin
            fifo_last_q <= 1'b1;
            frame_count <= frame_count + 32'd1;
            state       <= IDLE;
          end else if (byte_cnt == CNT_LIMIT) begin
            // Close the frame in the FIFO and discard the rest
            fifo_last_q  <= 1'b1;
            err_oversize <= 1'b1;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (cur_last_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_matrix_tx_arbiter.sv
// Bench for fifo_matrix_tx_arbiter: requester/FIFO driver plus a frame-level
// reference model (grant order, write schedule, truncation, frame count).
`define CHK(TAG, OBS, EXP) \
  begin \
    total++; \
    assert ((OBS) === (EXP)) else begin \
      bad++; \
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", TAG, OBS, EXP, cyc); \
    end \
  end

module tb_fifo_matrix_tx_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 1518;

  typedef struct { int len; int fixed; } frame_t;
  typedef struct { int cyc; logic [7:0] data; logic last; logic err; logic done; } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        busy;
  logic [1:0]  grant_idx;
  logic        err_oversize;
  logic [31:0] frame_count;

  fifo_matrix_tx_arbiter_if #(.PORT_COUNT(N), .DATA_WIDTH(DW)) bus();

  fifo_matrix_tx_arbiter #(.PORT_COUNT(N), .DATA_WIDTH(DW), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .err_oversize (err_oversize),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  frame_t      frames_q [N][$];
  wr_t         exp_q [$];
  int          free_from;
  int          rr;
  int          model_fc;
  int          busy_lo;
  int          busy_hi;
  logic [N-1:0] prev_valid;
  logic        prev_pf;
  logic        pf_drive;
  int          s_req, s_len, s_start;
  bit          s_active;
  logic [7:0]  s_bytes [0:2047];
  int          obs_writes;
  int          obs_errs;
  int          grant_log [$];

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (frames_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model a grant to requester g at the current cycle: stream plan and expected writes
  task automatic start_frame(input int g);
    frame_t f;
    wr_t    e;
    f = frames_q[g].pop_front();
    rr = (g + 1) % N;
    s_req = g; s_len = f.len; s_start = cyc + 1; s_active = 1'b1;
    free_from = cyc + f.len + 1;
    busy_lo = cyc + 1;
    busy_hi = (f.len > MAXB) ? cyc + f.len : cyc + f.len + 1;
    for (int k = 0; k < f.len; k++) begin
      s_bytes[k] = (f.fixed < 0) ? 8'($urandom) : 8'(f.fixed);
      if (k < MAXB) begin
        e.cyc  = cyc + 2 + k;
        e.data = s_bytes[k];
        e.last = (k == f.len - 1) || (k == MAXB - 1);
        e.err  = (k == MAXB - 1) && (f.len > MAXB);
        e.done = (k == f.len - 1) && (f.len <= MAXB);
        exp_q.push_back(e);
      end
    end
  endtask

  // Advance one cycle and compare every output with the model
  task automatic tick_check();
    logic [N-1:0] exp_rdy;
    int   g;
    logic exp_wr, exp_err, exp_busy;
    wr_t  e;
    @(posedge clk);
    #1;
    cyc++;
    exp_rdy = '0;
    g = -1;
    if (cyc - 1 >= free_from && !prev_pf && prev_valid != '0) begin
      for (int off = 0; off < N; off++)
        if (g < 0 && prev_valid[(rr + off) % N]) g = (rr + off) % N;
      exp_rdy[g] = 1'b1;
      start_frame(g);
    end
    `CHK("req_ready", bus.req_ready, exp_rdy)
    if (g >= 0) `CHK("grant_idx", grant_idx, 2'(g))
    if (|bus.req_ready) grant_log.push_back(int'(grant_idx));

    exp_wr = 1'b0;
    exp_err = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      exp_wr = 1'b1;
      exp_err = e.err;
      if (e.done) model_fc++;
    end
    `CHK("fifo_wr_en", bus.fifo_wr_en, exp_wr)
    if (exp_wr) begin
      `CHK("fifo_din", bus.fifo_din, e.data)
      `CHK("fifo_last", bus.fifo_last, e.last)
    end
    `CHK("err_oversize", err_oversize, exp_err)
    `CHK("frame_count", frame_count, 32'(model_fc))
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    `CHK("busy", busy, exp_busy)
    if (bus.fifo_wr_en) obs_writes++;
    if (err_oversize) obs_errs++;
  endtask

  // Drive this cycle's requester and FIFO inputs
  task automatic drive();
    int k;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (frames_q[i].size() > 0);
      bus.in_data[i*DW +: DW] = 8'($urandom);
      bus.in_last[i] = 1'($urandom);
    end
    if (s_active && cyc >= s_start) begin
      k = cyc - s_start;
      bus.in_data[s_req*DW +: DW] = s_bytes[k];
      bus.in_last[s_req] = (k == s_len - 1);
      if (k == s_len - 1) s_active = 1'b0;
    end
    bus.fifo_prog_full = pf_drive;
    prev_valid = bus.req_valid;
    prev_pf = pf_drive;
  endtask

  task automatic step();
    tick_check();
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((pending() || s_active || exp_q.size() > 0 || cyc <= busy_hi) && n < budget) begin
      step();
      n++;
    end
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL drain_timeout: observed=%0d expected<%0d", n, budget);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) frames_q[i].delete();
    exp_q.delete();
    s_active = 1'b0;
    rr = 0;
    model_fc = 0;
    busy_lo = 1;
    busy_hi = 0;
    free_from = 1 << 30;
    prev_valid = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int base, n, fc_before, r;

    bus.req_valid = '0;
    bus.in_data = '0;
    bus.in_last = '0;
    bus.fifo_prog_full = 1'b0;
    pf_drive = 1'b0;
    prev_pf = 1'b0;
    clear_model();
    obs_writes = 0;
    obs_errs = 0;

    // Reset state
    #1 reset_n = 1'b0;
    step();
    step();
    `CHK("rst_grant_idx", grant_idx, 2'd0)
    `CHK("rst_fifo_din", bus.fifo_din, 8'h00)
    `CHK("rst_fifo_last", bus.fifo_last, 1'b0)
    #4 reset_n = 1'b1;
    free_from = cyc;

    // Round robin with all four requesting, requester 0 twice
    grant_log.delete();
    obs_writes = 0;
    for (int i = 0; i < N; i++) frames_q[i].push_back('{4, -1});
    frames_q[0].push_back('{4, -1});
    run_idle(200);
    `CHK("rr_grants", grant_log.size(), 5)
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) `CHK("rr_order", grant_log[i], exp_order[i])
    `CHK("rr_writes", obs_writes, 20)
    `CHK("rr_frame_count", frame_count, 32'd5)

    // Single 1-byte frame from requester 2
    obs_writes = 0;
    frames_q[2].push_back('{1, 'hA5});
    run_idle(100);
    `CHK("one_byte_writes", obs_writes, 1)
    `CHK("one_byte_count", frame_count, 32'd6)
    `CHK("one_byte_gidx", grant_idx, 2'd2)

    // Backpressure: no grant while prog_full, grant soon after it drops
    pf_drive = 1'b1;
    base = grant_log.size();
    obs_writes = 0;
    frames_q[1].push_back('{12, -1});
    for (int i = 0; i < 6; i++) step();
    `CHK("bp_no_grant", grant_log.size(), base)
    pf_drive = 1'b0;
    step();
    step();
    step();
    `CHK("bp_grant_after_drop", grant_log.size(), base + 1)
    `CHK("bp_grant_idx", grant_idx, 2'd1)
    pf_drive = 1'b1;
    for (int i = 0; i < 16; i++) step();
    `CHK("bp_midframe_writes", obs_writes, 12)
    frames_q[3].push_back('{5, -1});
    for (int i = 0; i < 5; i++) step();
    `CHK("bp_held_off", grant_log.size(), base + 1)
    pf_drive = 1'b0;
    run_idle(100);

    // Oversize frame followed by another requester
    obs_writes = 0;
    obs_errs = 0;
    fc_before = model_fc;
    base = grant_log.size();
    frames_q[0].push_back('{1600, -1});
    frames_q[1].push_back('{3, -1});
    run_idle(3000);
    `CHK("ovs_writes", obs_writes, MAXB + 3)
    `CHK("ovs_err_pulses", obs_errs, 1)
    `CHK("ovs_frame_count", frame_count, 32'(fc_before + 1))
    `CHK("ovs_next_grant", grant_log[grant_log.size() - 1], 1)

    // Exactly maximum-length frame is not truncated
    obs_errs = 0;
    fc_before = model_fc;
    frames_q[2].push_back('{MAXB, -1});
    run_idle(2000);
    `CHK("max_len_err", obs_errs, 0)
    `CHK("max_len_count", frame_count, 32'(fc_before + 1))

    // Random traffic with prog_full toggling and withdrawn requests
    for (int j = 0; j < 800; j++) begin
      tick_check();
      if ($urandom_range(0, 3) == 0)
        frames_q[$urandom_range(0, N - 1)].push_back('{int'($urandom_range(1, 40)), -1});
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, N - 1);
        if (frames_q[r].size() > 0) void'(frames_q[r].pop_back());
      end
      pf_drive = ($urandom_range(0, 4) == 0);
      drive();
    end
    pf_drive = 1'b0;
    run_idle(5000);

    // Asynchronous reset during byte 10 of a 64-byte frame
    frames_q[1].push_back('{64, -1});
    n = 0;
    while (!(s_active && s_req == 1 && cyc - s_start == 10) && n < 200) begin
      step();
      n++;
    end
    `CHK("rst_mid_reached", n < 200, 1'b1)
    #2 reset_n = 1'b0;
    #1;
    `CHK("amid_req_ready", bus.req_ready, 4'h0)
    `CHK("amid_wr_en", bus.fifo_wr_en, 1'b0)
    `CHK("amid_din", bus.fifo_din, 8'h00)
    `CHK("amid_last", bus.fifo_last, 1'b0)
    `CHK("amid_busy", busy, 1'b0)
    `CHK("amid_grant_idx", grant_idx, 2'd0)
    `CHK("amid_err", err_oversize, 1'b0)
    `CHK("amid_frame_count", frame_count, 32'd0)
    clear_model();
    step();
    step();
    #4 reset_n = 1'b1;
    free_from = cyc;

    // Pointer restarts at 0 after reset
    frames_q[1].push_back('{3, -1});
    frames_q[2].push_back('{3, -1});
    base = grant_log.size();
    run_idle(100);
    `CHK("post_rst_first", grant_log[base], 1)
    frames_q[3].push_back('{4, -1});
    run_idle(100);
    `CHK("post_rst_grant3", grant_log[grant_log.size() - 1], 3)
    `CHK("post_rst_count", frame_count, 32'd3)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
